// File: rtl/reg_file_write_ctrl.sv
// reg_file_write_ctrl: debounced pushbutton front end that issues one write
// strobe per accepted press into a 4-entry register file. In auto mode the
// address comes from an internal wrapping pointer; in manual mode it comes
// from addr_sw.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for synchronized button high
// PRESS   | button high, counting stable cycles before accepting press
// HELD    | press accepted (write issued on entry), waiting for release
// RELEASE | button low, counting stable cycles before returning to IDLE
module reg_file_write_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn,
  input  logic [3:0] data_sw,
  input  logic       mode,
  input  logic [1:0] addr_sw,
  output logic [3:0] in,
  output logic [1:0] writeAddress,
  output logic       write,
  output logic       busy,
  output logic       all_written
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;
  logic             btn_m, btn_s;
  logic [1:0]       ptr;
  logic [3:0]       mask;
  logic             auto_cap;

  // Two-flop synchronizer; btn_s is the only view of the button.
  always_ff @(posedge clk) begin
    if (!clr) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // State and debounce counter registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and capture decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end
      end
      PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Write datapath: capture inputs on acceptance, then retire the write by
  // marking the address and advancing the auto pointer when it was used.
  always_ff @(posedge clk) begin
    if (!clr) begin
      in           <= '0;
      writeAddress <= '0;
      write        <= 1'b0;
      ptr          <= '0;
      mask         <= '0;
      auto_cap     <= 1'b0;
    end else begin
      write <= capture;
      if (capture) begin
        in           <= data_sw;
        writeAddress <= mode ? addr_sw : ptr;
        auto_cap     <= ~mode;
      end
      if (write) begin
        mask[writeAddress] <= 1'b1;
        if (auto_cap) begin
          ptr <= ptr + 2'd1;
        end
      end
    end
  end

  assign busy        = (state != IDLE);
  assign all_written = &mask;

endmodule

// File: doc/reg_file_write_ctrl.md
REG_FILE_WRITE_CTRL -- requirements
Module: reg_file_write_ctrl

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 50000, number of consecutive stable synchronized cycles required to accept a press or release (minimum 2).
REQ-002 SHALL have parameter: CNT_W, default 16, width of the debounce counter; SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 SHALL have port: clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port: clr  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port: btn  input  1  raw asynchronous write pushbutton, active-high.
REQ-006 SHALL have port: data_sw  input  4  data word to be written.
REQ-007 SHALL have port: mode  input  1  0 = auto-increment address, 1 = manual address from addr_sw.
REQ-008 SHALL have port: addr_sw  input  2  manual write address.
REQ-009 SHALL have port: in  output  4  registered data to the register file data input.
REQ-010 SHALL have port: writeAddress  output  2  registered register file write address.
REQ-011 SHALL have port: write  output  1  single-cycle register file write strobe.
REQ-012 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port: all_written  output  1  high once each of the four addresses has been written since reset.

Function
REQ-014 SHALL pass btn through a two-flop synchronizer (btn_s); no other logic SHALL sample btn directly.
REQ-015 SHALL implement FSM states IDLE, PRESS, HELD, RELEASE.
REQ-016 IDLE: btn_s=1 -> PRESS, counter cleared to 0.
REQ-017 PRESS: btn_s=0 -> IDLE, no write; otherwise counter increments; when counter==DEBOUNCE_CYCLES-1 and btn_s=1 -> HELD.
REQ-018 On the PRESS->HELD edge: in <= data_sw; writeAddress <= (mode ? addr_sw : ptr); write <= 1.
REQ-019 write SHALL be high for exactly one cycle (first cycle in HELD) per accepted press; in and writeAddress SHALL hold until the next accepted press.
REQ-020 The 2-bit auto pointer ptr SHALL increment, wrapping 3->0, on the edge ending the write cycle, only if mode was 0 at capture; manual writes SHALL leave ptr unchanged.
REQ-021 HELD: btn_s=0 -> RELEASE, counter cleared; otherwise remain, no further writes.
REQ-022 RELEASE: btn_s=1 -> HELD (bounce; no new write); otherwise counter increments; at DEBOUNCE_CYCLES-1 -> IDLE.
REQ-023 Latency: with btn held high steadily from the first edge that samples it high, write SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3.
REQ-024 mode, addr_sw and data_sw SHALL be sampled only on the capture edge; changes at other times SHALL have no effect.
REQ-025 A 4-bit written mask SHALL set bit writeAddress on each write; all_written = AND of mask; it SHALL stay high until reset.
REQ-026 busy SHALL be combinationally derived from state (state != IDLE).

Reset
REQ-027 With clr=0 at a rising edge: state IDLE, counter 0, synchronizer flops 0, ptr 0, mask 0, in 0, writeAddress 0, write 0, busy 0, all_written 0.
REQ-028 Reset asserted mid-operation (including the write cycle) SHALL take effect on that edge; no write SHALL be issued for the interrupted press.
REQ-029 After clr returns to 1, a button already held high SHALL be treated as a new press (full debounce required).

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Auto mode: four clean presses with data_sw=A,5,C,3 -> writes at addresses 0,1,2,3 with those data; all_written=1 after the fourth write; fifth press writes address 0.
REQ-031 Latency: btn high from edge 1 -> write=1 only in the cycle after edge 7, one cycle wide, busy=1 from edge 3.
REQ-032 Bounce: btn high for 2 cycles, low 1, high steadily -> exactly one write; bounce during RELEASE (low 2, high 1, low steadily) -> no extra write.
REQ-033 Manual mode: mode=1, addr_sw=2, data_sw=9 -> writeAddress=2, in=9, ptr unchanged (next auto write goes to prior ptr).
REQ-034 Reset: clr=0 on the write cycle -> write=0 next cycle, all outputs 0; btn still held after release of clr -> new write only after full debounce, at address 0.
